// File: rtl/board_pkg.sv
// Shared board geometry, FSM state type and a popcount helper for the
// selection controller.
package board_pkg;

  localparam int unsigned BOARD_DIM   = 6;
  localparam int unsigned BOARD_CELLS = 36;
  localparam int unsigned MAX_PAIRS   = 18;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    PAIR  = 2'd1,
    APPLY = 2'd2,
    WON   = 2'd3
  } state_e;

  function automatic logic [5:0] popcount(input logic [BOARD_CELLS-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < BOARD_CELLS; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/cursor_nav.sv
// Combinational cursor step on the 6x6 board: saturating moves with
// priority up > down > left > right.
module cursor_nav
  import board_pkg::*;
(
  input  logic [5:0] cur_i,
  input  logic       up_i,
  input  logic       down_i,
  input  logic       left_i,
  input  logic       right_i,
  output logic [5:0] next_o
);

  localparam logic [5:0] DIM  = 6'(BOARD_DIM);
  localparam logic [5:0] LAST = 6'(BOARD_DIM - 1);

  logic [5:0] row;
  logic [5:0] col;

  assign row = cur_i / DIM;
  assign col = cur_i % DIM;

  always_comb begin
    next_o = cur_i;
    if (up_i) begin
      if (row != '0) next_o = cur_i - DIM;
    end else if (down_i) begin
      if (row != LAST) next_o = cur_i + DIM;
    end else if (left_i) begin
      if (col != '0) next_o = cur_i - 6'd1;
    end else if (right_i) begin
      if (col != LAST) next_o = cur_i + 6'd1;
    end
  end

endmodule

// File: rtl/selection_controller.sv
// Card selection controller for a 6x6 matching game.
// Optional matched-pair score counter/port enabled by SELCTRL_SCORE_EN.
module selection_controller
  import board_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic        en_input,
  input  logic        ms,
  input  logic        mf,
  output logic [35:0] sel_bus,
  output logic [35:0] hidden_bus,
  output logic [5:0]  cursor,
  output logic        game_over
`ifdef SELCTRL_SCORE_EN
  ,
  output logic [4:0]  score
`endif
);

  state_e      state_q, state_d;
  logic [35:0] sel_q, sel_d;
  logic [35:0] hidden_q, hidden_d;
  logic [5:0]  cursor_q, cursor_d;
  logic        match_q, match_d;
  logic        ms_prev_q, mf_prev_q;
  logic        ms_rise, mf_rise;
  logic [5:0]  nav_next;

  cursor_nav u_nav (
    .cur_i   (cursor_q),
    .up_i    (btn_up),
    .down_i  (btn_down),
    .left_i  (btn_left),
    .right_i (btn_right),
    .next_o  (nav_next)
  );

  assign ms_rise = ms & ~ms_prev_q;
  assign mf_rise = mf & ~mf_prev_q;

`ifdef SELCTRL_SCORE_EN
  logic [4:0] score_q, score_d;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    hidden_d = hidden_q;
    cursor_d = cursor_q;
    match_d  = match_q;
`ifdef SELCTRL_SCORE_EN
    score_d  = score_q;
`endif
    case (state_q)
      PLAY: begin
        if (en_input) begin
          // Select takes precedence over any simultaneous move.
          if (btn_sel) begin
            if (!hidden_q[cursor_q]) begin
              sel_d[cursor_q] = ~sel_q[cursor_q];
              if (popcount(sel_d) == 6'd2) state_d = PAIR;
            end
          end else begin
            cursor_d = nav_next;
          end
        end
      end
      PAIR: begin
        if (ms_rise) begin
          match_d = 1'b1;
          state_d = APPLY;
        end else if (mf_rise) begin
          match_d = 1'b0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (match_q) begin
          hidden_d = hidden_q | sel_q;
`ifdef SELCTRL_SCORE_EN
          if (score_q < 5'(MAX_PAIRS)) score_d = score_q + 5'd1;
`endif
        end
        sel_d   = '0;
        state_d = (&hidden_d) ? WON : PLAY;
      end
      WON: ;
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PLAY;
      sel_q     <= '0;
      hidden_q  <= '0;
      cursor_q  <= '0;
      match_q   <= 1'b0;
      ms_prev_q <= 1'b0;
      mf_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      hidden_q  <= hidden_d;
      cursor_q  <= cursor_d;
      match_q   <= match_d;
      ms_prev_q <= ms;
      mf_prev_q <= mf;
    end
  end

`ifdef SELCTRL_SCORE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) score_q <= '0;
    else     score_q <= score_d;
  end
  assign score = score_q;
`endif

  assign sel_bus    = sel_q;
  assign hidden_bus = hidden_q;
  assign cursor     = cursor_q;
  assign game_over  = &hidden_q;

endmodule
